alu_seg_scan: RTL

Display stage directly downstream of the 4-bit ALU. It takes the ALU operands, the current mode, the result and the flags, and drives an 8-digit multiplexed common-anode seven-segment display. A free-running divider scans the digits. Inputs are captured once per frame into shadow registers so a refresh never shows a mix of old and new values. A short all-off blanking window at each digit change suppresses ghosting.

---
 rtl/alu_seg_scan.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_seg_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_seg_scan
// Brief    : 8-digit multiplexed seven-segment display of ALU operands, mode,
//            result and flags, with per-frame input snapshot and blanking.
// Revision : 1.0
// ============================================================================
module alu_seg_scan #(
    parameter int SCAN_DIV = 100000,
    parameter int BLANK    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [2:0] mode,
    input  logic [3:0] result,
    input  logic       zf,
    input  logic       of,
    input  logic       cf,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int            CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] C_BLANK    = CW'(BLANK);
    localparam logic [6:0]    C_SEG_OFF  = 7'h7F;
    localparam logic [7:0]    C_AN_OFF   = 8'hFF;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic          r_primed;

    logic [3:0]    r_a;
    logic [3:0]    r_b;
    logic [2:0]    r_mode;
    logic [3:0]    r_result;
    logic          r_zf;
    logic          r_of;
    logic          r_cf;

    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_cnt_last;
    logic          w_load;
    logic          w_dark;
    logic [7:0]    w_an_lit;
    logic [6:0]    w_seg_lit;
    logic          w_dp_lit;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Snapshot on the first edge after reset and on the last cycle of a frame,
    // so the next digit-7 slot always shows fresh values.
    assign w_cnt_last = (r_cnt == C_CNT_LAST);
    assign w_load     = !r_primed || (w_cnt_last && (r_idx == 3'd0));
    assign w_dark     = (r_cnt < C_BLANK);
    assign w_an_lit   = ~(8'h01 << r_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= 3'd7;
        end else if (w_cnt_last) begin
            r_cnt <= '0;
            r_idx <= r_idx - 3'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_primed <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= '0;
            r_result <= '0;
            r_zf     <= 1'b0;
            r_of     <= 1'b0;
            r_cf     <= 1'b0;
        end else begin
            r_primed <= 1'b1;
            if (w_load) begin
                r_a      <= A;
                r_b      <= B;
                r_mode   <= mode;
                r_result <= result;
                r_zf     <= zf;
                r_of     <= of;
                r_cf     <= cf;
            end
        end
    end

    always_comb begin
        w_seg_lit = C_SEG_OFF;
        w_dp_lit  = 1'b1;
        case (r_idx)
            3'd7: w_seg_lit = hex7(r_a);
            3'd6: w_seg_lit = hex7(r_b);
            3'd5: begin
                w_seg_lit = hex7({1'b0, r_mode});
                w_dp_lit  = 1'b0;
            end
            3'd4: w_seg_lit = C_SEG_OFF;
            3'd3: w_seg_lit = hex7(r_result);
            3'd2: w_seg_lit = hex7({3'b000, r_zf});
            3'd1: w_seg_lit = hex7({3'b000, r_of});
            default: w_seg_lit = hex7({3'b000, r_cf});
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= C_AN_OFF;
            r_seg <= C_SEG_OFF;
            r_dp  <= 1'b1;
        end else if (w_dark) begin
            r_an  <= C_AN_OFF;
            r_seg <= C_SEG_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_lit;
            r_seg <= w_seg_lit;
            r_dp  <= w_dp_lit;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
`default_nettype wire
